// File: rtl/follower_pkg.sv
// Shared definitions for the line-follower command path: opcodes, controller states
// and the widths of the station and barcode ID fields.
package follower_pkg;

    localparam int ID_W  = 8;
    localparam int STN_W = 6;

    localparam logic [1:0] CMD_STOP = 2'b00;
    localparam logic [1:0] CMD_GO   = 2'b01;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_DRIVE = 1'b1
    } state_t;

endpackage

// File: rtl/buzz_gen.sv
// Piezo square-wave generator: while enabled, buzz toggles once every BUZZ_HALF clocks;
// when disabled the phase counter and output are parked at zero.
module buzz_gen #(
    parameter int BUZZ_HALF = 6250
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic buzz,
    output logic buzz_n
);

    localparam int CNT_W = (BUZZ_HALF > 1) ? $clog2(BUZZ_HALF) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUZZ_HALF - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            cnt  <= '0;
            buzz <= 1'b0;
        end else if (cnt == CNT_LAST) begin
            cnt  <= '0;
            buzz <= ~buzz;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign buzz_n = ~buzz;

endmodule

// File: rtl/station_cmd_cntrl.sv
// Station command controller: accepts GO/STOP commands and barcode station IDs,
// tracks the active destination and drives motion enable plus the obstacle buzzer.
module station_cmd_cntrl
    import follower_pkg::*;
#(
    parameter int BUZZ_HALF = 6250
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [7:0]      cmd,
    input  logic            cmd_rdy,
    output logic            clr_cmd_rdy,
    input  logic [ID_W-1:0] ID,
    input  logic            ID_vld,
    output logic            clr_ID_vld,
    input  logic            OK2Move,
    output logic            go,
    output logic            in_transit,
    output logic            buzz,
    output logic            buzz_n
);

    state_t           state;
    logic [STN_W-1:0] dest;
    logic [1:0]       opcode;
    logic             id_match;

    assign opcode   = cmd[7:6];
    assign id_match = (ID == {{(ID_W-STN_W){1'b0}}, dest});

    // Inputs pending during reset are left untouched so they are seen again from IDLE.
    assign clr_cmd_rdy = cmd_rdy & ~rst;
    assign clr_ID_vld  = ID_vld & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            dest       <= '0;
            in_transit <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_rdy && opcode == CMD_GO) begin
                        dest       <= cmd[STN_W-1:0];
                        in_transit <= 1'b1;
                        state      <= ST_DRIVE;
                    end
                end
                ST_DRIVE: begin
                    // A command always wins; a simultaneous ID is acknowledged and dropped.
                    if (cmd_rdy) begin
                        if (opcode == CMD_GO) begin
                            dest <= cmd[STN_W-1:0];
                        end else if (opcode == CMD_STOP) begin
                            in_transit <= 1'b0;
                            state      <= ST_IDLE;
                        end
                    end else if (ID_vld && id_match) begin
                        in_transit <= 1'b0;
                        state      <= ST_IDLE;
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    in_transit <= 1'b0;
                end
            endcase
        end
    end

    assign go = in_transit & OK2Move;

    buzz_gen #(
        .BUZZ_HALF(BUZZ_HALF)
    ) u_buzz (
        .clk   (clk),
        .rst   (rst),
        .en    (in_transit & ~OK2Move),
        .buzz  (buzz),
        .buzz_n(buzz_n)
    );

endmodule

// File: tb/tb_station_cmd_cntrl.sv
// Bench for station_cmd_cntrl: directed scenarios followed by random traffic, all
// checked every cycle against a destination/transit/blocked-time reference model.
module tb_station_cmd_cntrl;

    localparam int BH = 4;

    logic       clk;
    logic       rst;
    logic [7:0] cmd;
    logic       cmd_rdy;
    logic       clr_cmd_rdy;
    logic [7:0] ID;
    logic       ID_vld;
    logic       clr_ID_vld;
    logic       OK2Move;
    logic       go;
    logic       in_transit;
    logic       buzz;
    logic       buzz_n;

    station_cmd_cntrl #(
        .BUZZ_HALF(BH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd        (cmd),
        .cmd_rdy    (cmd_rdy),
        .clr_cmd_rdy(clr_cmd_rdy),
        .ID         (ID),
        .ID_vld     (ID_vld),
        .clr_ID_vld (clr_ID_vld),
        .OK2Move    (OK2Move),
        .go         (go),
        .in_transit (in_transit),
        .buzz       (buzz),
        .buzz_n     (buzz_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: where we are heading, whether we are travelling, and for how
    // many consecutive edges the robot has been held up by an obstacle.
    logic [5:0] m_dest;
    bit         m_transit;
    int         m_blocked;
    bit         m_known = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    task automatic cycle(input bit r, input bit cr, input logic [7:0] c,
                         input bit iv, input logic [7:0] id, input bit ok);
        bit exp_buzz;
        @(negedge clk);
        rst = r; cmd_rdy = cr; cmd = c; ID_vld = iv; ID = id; OK2Move = ok;
        #1;
        chk("clr_cmd_rdy", 32'(clr_cmd_rdy), 32'(cr && !r));
        chk("clr_ID_vld", 32'(clr_ID_vld), 32'(iv && !r));
        if (m_known) begin
            exp_buzz = ((m_blocked / BH) % 2) == 1;
            chk("in_transit", 32'(in_transit), 32'(m_transit));
            chk("go", 32'(go), 32'(m_transit && ok));
            chk("buzz", 32'(buzz), 32'(exp_buzz));
            chk("buzz_n", 32'(buzz_n), 32'(!exp_buzz));
        end
        // Advance the model across the coming rising edge.
        if (r) begin
            m_transit = 1'b0;
            m_dest    = '0;
            m_blocked = 0;
            m_known   = 1'b1;
        end else if (m_known) begin
            m_blocked = (m_transit && !ok) ? m_blocked + 1 : 0;
            if (cr) begin
                if (c[7:6] == 2'b01) begin
                    m_dest    = c[5:0];
                    m_transit = 1'b1;
                end else if (c[7:6] == 2'b00) begin
                    m_transit = 1'b0;
                end
            end else if (iv && m_transit && id == {2'b00, m_dest}) begin
                m_transit = 1'b0;
            end
        end
    endtask

    task automatic idle(input int n, input bit ok);
        for (int i = 0; i < n; i++) cycle(0, 0, 8'h00, 0, 8'h00, ok);
    endtask

    initial begin
        bit         r, cr, iv, ok;
        logic [7:0] c, id;
        int         ok_run;

        rst = 1'b1; cmd_rdy = 1'b0; cmd = '0; ID_vld = 1'b0; ID = '0; OK2Move = 1'b1;
        cycle(1, 0, 8'h00, 0, 8'h00, 1);
        cycle(1, 0, 8'h00, 0, 8'h00, 1);
        idle(1, 1);

        // GO to station 5, then a wrong and a right barcode.
        cycle(0, 1, 8'h45, 0, 8'h00, 1);
        idle(2, 1);
        cycle(0, 0, 8'h00, 1, 8'h03, 1);
        idle(1, 1);
        cycle(0, 0, 8'h00, 1, 8'h05, 1);
        idle(2, 1);

        // Obstacle while driving: buzzer toggles every BH cycles, clears when path frees.
        cycle(0, 1, 8'h45, 0, 8'h00, 1);
        idle(3 * BH + 1, 0);
        idle(3, 1);

        // STOP and matching ID in the same cycle.
        cycle(0, 1, 8'h00, 1, 8'h05, 1);
        idle(2, 1);

        // IDLE: stray ID and a reserved opcode are acknowledged without effect.
        cycle(0, 0, 8'h00, 1, 8'h00, 1);
        cycle(0, 1, 8'hC2, 0, 8'h00, 1);
        idle(2, 1);

        // Reset while buzzing, with a GO still pending across reset.
        cycle(0, 1, 8'h45, 0, 8'h00, 1);
        idle(BH + 2, 0);
        cycle(1, 1, 8'h47, 0, 8'h00, 0);
        cycle(0, 1, 8'h47, 0, 8'h00, 0);
        idle(2, 1);
        cycle(0, 0, 8'h00, 1, 8'h07, 1);
        idle(1, 1);

        // Random traffic with small station numbers so IDs often match.
        ok_run = 0;
        for (int i = 0; i < 3000; i++) begin
            r  = ($urandom_range(0, 199) == 0);
            cr = ($urandom_range(0, 3) == 0);
            c  = {2'($urandom_range(0, 3)), 6'($urandom_range(0, 3))};
            iv = ($urandom_range(0, 2) == 0);
            id = {(($urandom_range(0, 7) == 0) ? 2'b01 : 2'b00), 6'($urandom_range(0, 3))};
            if (ok_run == 0) ok_run = ($urandom_range(0, 3) == 0) ? -int'($urandom_range(1, 14))
                                                                   : int'($urandom_range(1, 10));
            ok = (ok_run > 0);
            ok_run = (ok_run > 0) ? ok_run - 1 : ok_run + 1;
            cycle(r, cr, c, iv, id, ok);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/station_cmd_cntrl.md
# station_cmd_cntrl

Command controller that sequences the barcode reader for the line-following robot. Consumes 8-bit commands from the UART receive path (cmd/cmd_rdy) and station IDs from the barcode block (ID/ID_vld), acknowledges both via clear pulses, and drives motion enable and obstacle buzzer. Sits between the comm receiver, the barcode reader, and the motion/PID controller.

## Interface
Parameters:
- BUZZ_HALF, 6250: clk cycles per buzzer half-period (4 kHz at 50 MHz).

Ports:
- clk  in  1  system clock; one clock, all logic on posedge.
- rst  in  1  reset is synchronous and active-high.
- cmd  in  8  command byte; valid while cmd_rdy high. [7:6] opcode, [5:0] destination station.
- cmd_rdy  in  1  command pending; held until cleared.
- clr_cmd_rdy  out  1  one-cycle acknowledge of cmd.
- ID  in  8  station ID from barcode reader; valid while ID_vld high.
- ID_vld  in  1  ID pending; held until cleared.
- clr_ID_vld  out  1  one-cycle acknowledge of ID.
- OK2Move  in  1  proximity sensor: 1 = path clear.
- go  out  1  motion enable to motion controller.
- in_transit  out  1  registered: robot has an active destination.
- buzz  out  1  piezo drive.
- buzz_n  out  1  complement of buzz.

## Operation
- Opcodes (cmd[7:6]): 2'b01 GO (dest = cmd[5:0]), 2'b00 STOP, 2'b10/2'b11 reserved (acknowledged, no effect).
- State machine, two states:
  - IDLE: in_transit=0. cmd_rdy & GO -> latch dest, set in_transit, go to DRIVE. cmd_rdy & other opcode -> acknowledge, stay. ID_vld -> acknowledge, discard, stay.
  - DRIVE: in_transit=1. cmd_rdy & GO -> latch new dest, stay. cmd_rdy & STOP -> clear in_transit, IDLE. cmd_rdy & reserved -> acknowledge, stay. ID_vld with no cmd_rdy -> acknowledge; ID == {2'b00, dest} clears in_transit and returns to IDLE; mismatch stays in DRIVE.
- Simultaneous cmd_rdy and ID_vld: command processed, ID acknowledged and discarded (both clr pulses same cycle).
- go = in_transit & OK2Move (combinational from registered in_transit).
- Buzzer: while in_transit & !OK2Move, buzz toggles every BUZZ_HALF cycles (counter 0..BUZZ_HALF-1, toggle at wrap). Otherwise counter held at 0 and buzz=0. buzz_n = ~buzz always.
- dest is 6 bits; ID[7:6] must be 00 to match.

## Timing
- Reset values: state IDLE, dest 0, in_transit 0, go 0, buzz 0, buzz_n 1, clr_cmd_rdy 0, clr_ID_vld 0, buzz counter 0.
- clr_cmd_rdy / clr_ID_vld: combinational, high in the same cycle cmd_rdy / ID_vld is observed high, for exactly that cycle. Upstream clears on that edge; no input processed twice.
- state, dest, in_transit update on the edge ending the acknowledge cycle; go follows one cycle after cmd_rdy rises (if OK2Move=1).
- Arrival: in_transit and go fall on the edge ending the ID_vld cycle.
- OK2Move falling: go drops same cycle; first buzz rise BUZZ_HALF cycles later.
- rst mid-DRIVE: next edge returns all to reset values; pending cmd_rdy/ID_vld re-evaluated from IDLE afterwards.

## Structure
- Shared package follower_pkg: opcode localparams (CMD_GO, CMD_STOP), state enum, ID width constant (8), station field width (6).
- One sub-module: buzz_gen (parameter BUZZ_HALF; inputs clk, rst, en; outputs buzz, buzz_n).

## Test plan
- Reset, then cmd=8'h45 pulse via cmd_rdy -> clr_cmd_rdy 1 cycle, in_transit=1, go=1 next cycle, dest=5.
- DRIVE dest=5, ID=8'h03 with ID_vld -> clr_ID_vld 1 cycle, in_transit stays 1; then ID=8'h05 -> in_transit and go 0 next edge, state IDLE.
- DRIVE, OK2Move=0 for 3*BUZZ_HALF cycles (BUZZ_HALF=4 in bench) -> go=0, buzz toggles at cycles 4,8,12, buzz_n complementary; OK2Move=1 -> buzz=0, go=1.
- DRIVE dest=5, cmd=8'h00 and ID=8'h05 same cycle -> both clr pulses high, in_transit 0, state IDLE via STOP.
- IDLE, ID_vld with ID=8'h00 -> clr_ID_vld 1 cycle, no state change; cmd=8'hC2 -> acknowledged, stays IDLE.
- rst asserted during DRIVE with buzz high -> after one edge all outputs at reset values.
